// File: rtl/id_ex.sv
// Decode-to-execute pipeline register: captures decode outputs each cycle,
// inserts a NOP bubble when decode stalls alone, and clears on exception flush.
module id_ex #(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [4:0]          id_wd,
  input  logic                id_wreg,
  input  logic [DATA_W-1:0]   id_link_address,
  input  logic                id_is_in_delayslot,
  input  logic                next_inst_in_delayslot_i,
  input  logic [DATA_W-1:0]   id_inst,
  input  logic [DATA_W-1:0]   id_excepttype,
  input  logic [DATA_W-1:0]   id_current_inst_address,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [4:0]          ex_wd,
  output logic                ex_wreg,
  output logic [DATA_W-1:0]   ex_link_address,
  output logic                ex_is_in_delayslot,
  output logic [DATA_W-1:0]   ex_inst,
  output logic [DATA_W-1:0]   ex_excepttype,
  output logic [DATA_W-1:0]   ex_current_inst_address,
  output logic                is_in_delayslot_o,
  output logic                ex_valid
);

  logic bubble;
  logic advance;

  assign bubble  = stall[2] & ~stall[3];
  // stall[2]=0 with stall[3]=1 never comes from the controller; treat as advance.
  assign advance = ~stall[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_aluop                <= '0;
      ex_alusel               <= '0;
      ex_reg1                 <= '0;
      ex_reg2                 <= '0;
      ex_wd                   <= '0;
      ex_wreg                 <= 1'b0;
      ex_link_address         <= '0;
      ex_is_in_delayslot      <= 1'b0;
      ex_inst                 <= '0;
      ex_excepttype           <= '0;
      ex_current_inst_address <= '0;
      is_in_delayslot_o       <= 1'b0;
      ex_valid                <= 1'b0;
    end else if (flush || bubble) begin
      ex_aluop                <= '0;
      ex_alusel               <= '0;
      ex_reg1                 <= '0;
      ex_reg2                 <= '0;
      ex_wd                   <= '0;
      ex_wreg                 <= 1'b0;
      ex_link_address         <= '0;
      ex_is_in_delayslot      <= 1'b0;
      ex_inst                 <= '0;
      ex_excepttype           <= '0;
      ex_current_inst_address <= '0;
      ex_valid                <= 1'b0;
      // The stalled decode instruction still needs its delay-slot flag.
      if (flush) is_in_delayslot_o <= 1'b0;
    end else if (advance) begin
      ex_aluop                <= id_aluop;
      ex_alusel               <= id_alusel;
      ex_reg1                 <= id_reg1;
      ex_reg2                 <= id_reg2;
      ex_wd                   <= id_wd;
      ex_wreg                 <= id_wreg;
      ex_link_address         <= id_link_address;
      ex_is_in_delayslot      <= id_is_in_delayslot;
      ex_inst                 <= id_inst;
      ex_excepttype           <= id_excepttype;
      ex_current_inst_address <= id_current_inst_address;
      is_in_delayslot_o       <= next_inst_in_delayslot_i;
      ex_valid                <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex.sv
// Directed self-checking bench for the id_ex pipeline register.
module tb_id_ex;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1, id_reg2, id_link_address, id_inst, id_excepttype, id_current_inst_address;
  logic [4:0]  id_wd;
  logic        id_wreg, id_is_in_delayslot, next_inst_in_delayslot_i;

  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2, ex_link_address, ex_inst, ex_excepttype, ex_current_inst_address;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_is_in_delayslot, is_in_delayslot_o, ex_valid;

  // model copy of the last instruction expected to sit in EX
  logic [7:0]  c_aluop;
  logic [2:0]  c_alusel;
  logic [31:0] c_reg1, c_reg2, c_link, c_inst, c_exc, c_addr;
  logic [4:0]  c_wd;
  logic        c_wreg, c_isds;

  int tests_run = 0;
  int tests_failed = 0;

  id_ex dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_link_address(id_link_address),
    .id_is_in_delayslot(id_is_in_delayslot), .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
    .id_inst(id_inst), .id_excepttype(id_excepttype), .id_current_inst_address(id_current_inst_address),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_link_address(ex_link_address),
    .ex_is_in_delayslot(ex_is_in_delayslot), .ex_inst(ex_inst), .ex_excepttype(ex_excepttype),
    .ex_current_inst_address(ex_current_inst_address), .is_in_delayslot_o(is_in_delayslot_o),
    .ex_valid(ex_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // derive a full, distinct decode bundle from a few seed values
  task automatic applyStimulus(input logic [7:0] aluop, input logic [31:0] r1, input logic [4:0] wd,
                               input logic wreg, input logic isds, input logic nextds);
    id_aluop                 = aluop;
    id_alusel                = aluop[2:0] | 3'b001;
    id_reg1                  = r1;
    id_reg2                  = ~r1;
    id_wd                    = wd;
    id_wreg                  = wreg;
    id_link_address          = r1 + 32'd8;
    id_is_in_delayslot       = isds;
    next_inst_in_delayslot_i = nextds;
    id_inst                  = {aluop, r1[23:0]};
    id_excepttype            = r1 ^ 32'hA5A5_5A5A;
    id_current_inst_address  = r1 + 32'd4;
  endtask

  task automatic capture();
    c_aluop = id_aluop; c_alusel = id_alusel; c_reg1 = id_reg1; c_reg2 = id_reg2;
    c_wd = id_wd; c_wreg = id_wreg; c_link = id_link_address; c_isds = id_is_in_delayslot;
    c_inst = id_inst; c_exc = id_excepttype; c_addr = id_current_inst_address;
  endtask

  // full = 1: expect captured instruction; full = 0: expect all-zero bubble
  task automatic checkAll(input string tag, input logic full, input logic ds);
    checkOutput({tag, ".aluop"},  32'(ex_aluop),  full ? 32'(c_aluop)  : 32'd0);
    checkOutput({tag, ".alusel"}, 32'(ex_alusel), full ? 32'(c_alusel) : 32'd0);
    checkOutput({tag, ".reg1"},   ex_reg1,        full ? c_reg1        : 32'd0);
    checkOutput({tag, ".reg2"},   ex_reg2,        full ? c_reg2        : 32'd0);
    checkOutput({tag, ".wd"},     32'(ex_wd),     full ? 32'(c_wd)     : 32'd0);
    checkOutput({tag, ".wreg"},   32'(ex_wreg),   full ? 32'(c_wreg)   : 32'd0);
    checkOutput({tag, ".link"},   ex_link_address, full ? c_link       : 32'd0);
    checkOutput({tag, ".isds"},   32'(ex_is_in_delayslot), full ? 32'(c_isds) : 32'd0);
    checkOutput({tag, ".inst"},   ex_inst,        full ? c_inst        : 32'd0);
    checkOutput({tag, ".exc"},    ex_excepttype,  full ? c_exc         : 32'd0);
    checkOutput({tag, ".pc"},     ex_current_inst_address, full ? c_addr : 32'd0);
    checkOutput({tag, ".ds_o"},   32'(is_in_delayslot_o), 32'(ds));
    checkOutput({tag, ".valid"},  32'(ex_valid),  32'(full));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    applyStimulus(8'h25, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b1);
    capture();
    tick();
    checkAll("adv0", 1'b1, 1'b1);

    // asynchronous reset mid-cycle, no clock edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll("rst_async", 1'b0, 1'b0);
    tick();
    checkAll("rst_held", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h25, 32'h1234_5678, 5'd3, 1'b1, 1'b0, 1'b0);
    capture();
    tick();
    checkAll("rst_release", 1'b1, 1'b0);

    @(negedge clk);
    applyStimulus(8'h1A, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0, 1'b1);
    capture();
    tick();
    checkAll("adv1", 1'b1, 1'b1);

    // bubble: delay-slot flag must hold at 1 while next_inst toggles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 6'b000111;
      applyStimulus(8'h33 + 8'(i), 32'h0BAD_0000 + 32'(i), 5'd9, 1'b1, 1'b1, i[0] ? 1'b1 : 1'b0);
      tick();
      checkAll("bubble", 1'b0, 1'b1);
    end

    @(negedge clk);
    stall = 6'b0;
    applyStimulus(8'h44, 32'hCAFE_F00D, 5'd7, 1'b1, 1'b1, 1'b1);
    capture();
    tick();
    checkAll("adv2", 1'b1, 1'b1);

    // full hold: everything frozen while inputs keep changing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 6'b001111;
      applyStimulus(8'h60 + 8'(i), 32'h5555_0000 + 32'(i), 5'd12, 1'b0, 1'b0, 1'b0);
      tick();
      checkAll("hold", 1'b1, 1'b1);
    end

    @(negedge clk);
    flush = 1'b1;
    stall = 6'b001111;
    applyStimulus(8'h77, 32'h7777_7777, 5'd15, 1'b1, 1'b1, 1'b1);
    tick();
    checkAll("flush", 1'b0, 1'b0);

    // branch followed by its delay-slot instruction
    @(negedge clk);
    flush = 1'b0;
    stall = 6'b0;
    applyStimulus(8'h50, 32'h0040_0100, 5'd31, 1'b1, 1'b0, 1'b1);
    capture();
    tick();
    checkAll("branch", 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(8'h21, 32'h0040_0104, 5'd4, 1'b1, 1'b1, 1'b0);
    capture();
    tick();
    checkAll("dslot", 1'b1, 1'b0);

    // illegal stall pattern behaves as advance
    @(negedge clk);
    stall = 6'b001000;
    applyStimulus(8'h0F, 32'h8000_0001, 5'd1, 1'b1, 1'b0, 1'b1);
    capture();
    tick();
    checkAll("stall3_only", 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex.md
Name: id_ex

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage MIPS32 core.
- Captures every decode output each cycle.
- Honours the central stall vector and the exception flush.
- Inserts a NOP bubble when decode stalls but execute runs.
- Returns the registered "next instruction is in delay slot" flag to decode as its is_in_delayslot input.

Parameters:
- DATA_W, 32, width of data, address, instruction and except-type fields.
- ALUOP_W, 8, width of the aluop field.
- ALUSEL_W, 3, width of the alusel field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  stall vector; [2]=decode stalled, [3]=execute stalled.
- flush  in  1  exception flush; highest priority.
- id_aluop  in  ALUOP_W  decoded ALU op.
- id_alusel  in  ALUSEL_W  decoded ALU select.
- id_reg1  in  DATA_W  source operand 1.
- id_reg2  in  DATA_W  source operand 2.
- id_wd  in  5  destination register.
- id_wreg  in  1  destination write enable.
- id_link_address  in  DATA_W  link address for jal/bal.
- id_is_in_delayslot  in  1  decoded instruction is a delay-slot instruction.
- next_inst_in_delayslot_i  in  1  instruction after the current one is a delay slot.
- id_inst  in  DATA_W  raw instruction word.
- id_excepttype  in  DATA_W  exception flags collected so far.
- id_current_inst_address  in  DATA_W  PC of the instruction.
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_address, ex_is_in_delayslot, ex_inst, ex_excepttype, ex_current_inst_address  out  (widths as the matching id_ input)  registered copies of the id_ inputs.
- is_in_delayslot_o  out  1  registered next_inst_in_delayslot_i, fed back to decode.
- ex_valid  out  1  1 = real instruction in EX; 0 = bubble or reset.

Behaviour:
- Reset and flush values:
  - All ex_* outputs, is_in_delayslot_o and ex_valid are 0.
  - aluop 0 = NOP; alusel 0 = NOP.
  - Reset is asynchronous; it clears outputs immediately, mid-operation included.
- Per-cycle priority, evaluated at each rising edge:
  1. flush=1: load reset values, regardless of stall.
  2. stall[2]=1 and stall[3]=0 (bubble):
     - All ex_* outputs load reset values; ex_valid=0.
     - is_in_delayslot_o HOLDS, because the stalled decode instruction still needs it.
  3. stall[2]=0 (advance):
     - All ex_* outputs load their id_* inputs.
     - is_in_delayslot_o <= next_inst_in_delayslot_i.
     - ex_valid <= 1.
  4. Otherwise (stall[2]=1 and stall[3]=1): every register holds.
- Illegal combination stall[2]=0 with stall[3]=1 is not generated by the controller; the block treats it as advance.
- Latency: exactly one cycle from id_* to ex_*. No combinational path from any input to any output.
- A bubble carries wreg=0, so bypass comparators in decode see no write.
- excepttype and current_inst_address are zero during a bubble; commit logic must qualify them with ex_valid.
- Branch with a delay slot:
  - Cycle N advances the branch with next_inst_in_delayslot_i=1.
  - Cycle N+1 decode sees is_in_delayslot_o=1; the slot instruction advances with id_is_in_delayslot=1, next_inst_in_delayslot_i=0.
  - Flag returns to 0 in cycle N+2.

Test Plan:
- Reset: rst=0 with nonzero inputs -> every output 0 at once, without waiting for a clock edge. Release rst with stall=0 -> first edge copies inputs; ex_valid=1.
- Advance: id_aluop=8'h25, id_reg1=32'h1234_5678, id_wd=5'd3, id_wreg=1, stall=0 -> next cycle same values on ex_*; ex_valid=1.
- Bubble: stall=6'b000111 with next_inst_in_delayslot_i toggling, prior is_in_delayslot_o=1 -> ex_aluop=0, ex_wreg=0, ex_valid=0; is_in_delayslot_o stays 1.
- Hold: stall=6'b001111 for 3 cycles while inputs change -> ex_* and ex_valid frozen at pre-stall values.
- Flush priority: flush=1 together with stall=6'b001111 and valid inputs -> all outputs 0 next edge, is_in_delayslot_o included.
- Delay-slot sequence: branch (next_inst_in_delayslot_i=1), then slot instruction (id_is_in_delayslot=1) -> is_in_delayslot_o is 1 then 0; ex_is_in_delayslot is 0 then 1.
